// File: rtl/anode_scanner_pkg.sv
// Shared definitions for the anode scanner and the future cathode decoder:
// scan-state enum and set-bit search helpers over a digit mask.
package anode_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ON
    } scan_state_e;

    // Helpers work on a mask zero-extended to the widest supported display.
    localparam int MAX_DIGITS = 16;
    localparam int IDX_W      = 4;

    typedef logic [MAX_DIGITS-1:0] mask_t;

    // Index of the lowest set bit among the first n bits (0 if none set).
    function automatic int lowest_set(mask_t m, int n);
        int r;
        r = 0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < n && m[i[IDX_W-1:0]]) r = i;
        end
        return r;
    endfunction

    // Next set bit above cur, wrapping n-1 -> 0; returns cur when it is the
    // only candidate so a single-digit mask reloads the same index.
    function automatic int next_set(mask_t m, int n, int cur);
        int r;
        int j;
        r = cur;
        for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
            if (k < n) begin
                j = (cur + k) % n;
                if (m[j[IDX_W-1:0]]) r = j;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/anode_scanner_if.sv
// Display-side bundle of the anode scanner: mask/brightness controls in,
// anode enables and digit select/strobe out.
interface anode_scanner_if #(
    parameter int NUM_DIGITS   = 8,
    parameter int BRIGHT_WIDTH = 4
);
    localparam int SEL_W = $clog2(NUM_DIGITS);

    logic [NUM_DIGITS-1:0]   DigitMask;
    logic [BRIGHT_WIDTH-1:0] Brightness;
    logic [NUM_DIGITS-1:0]   Anode;
    logic [SEL_W-1:0]        DigitSel;
    logic                    DigitStrobe;

    // Controller side: owns mask and brightness.
    modport master (
        output DigitMask, Brightness,
        input  Anode, DigitSel, DigitStrobe
    );

    // Scanner side.
    modport slave (
        input  DigitMask, Brightness,
        output Anode, DigitSel, DigitStrobe
    );
endinterface

// File: rtl/anode_scanner_pwm.sv
// Brightness PWM for the anode scanner: a counter that restarts with each
// dwell and a comparator producing the gate for the upcoming cycle.
module scan_pwm #(
    parameter int BRIGHT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [BRIGHT_WIDTH-1:0] brightness,
    output logic                    gate
);
    logic [BRIGHT_WIDTH-1:0] pwm_q, pwm_d;

    // Next count and gate; gate is judged on the next count so it lines up
    // with the registered anode it feeds.
    always_comb begin
        pwm_d = clear ? '0 : pwm_q + BRIGHT_WIDTH'(1);
        gate  = (pwm_d < brightness) || (&brightness);
    end

    // PWM counter register.
    always_ff @(posedge clk) begin
        if (rst) pwm_q <= '0;
        else     pwm_q <= pwm_d;
    end
endmodule

// File: rtl/anode_scanner.sv
// Multiplexed common-anode digit scanner: dwell timing, masked digit
// rotation, PWM brightness and active-low registered anode enables.
// Optional ghost blanking at the start of each dwell: GHOST_BLANK_EN.
module anode_scanner
    import anode_scanner_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BRIGHT_WIDTH = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    anode_scanner_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(DWELL_CYCLES);
`ifdef GHOST_BLANK_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    scan_state_e           state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  strobe_q, strobe_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    mask_t                 mask_ext;
    logic                  terminal;
    logic                  pwm_clear;
    logic                  pwm_gate;

    // Next scan state: idle on empty mask, otherwise load/advance at the
    // dwell boundary; state/counter values here are those of the next cycle.
    always_comb begin
        mask_ext                   = '0;
        mask_ext[NUM_DIGITS-1:0]   = bus.DigitMask;
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        terminal = (int'(cnt_q) == DWELL_CYCLES - 1);
        if (bus.DigitMask == '0) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            if (state_q == IDLE) begin
                sel_d    = SEL_W'(lowest_set(mask_ext, NUM_DIGITS));
                cnt_d    = '0;
                strobe_d = 1'b1;
            end else if (terminal) begin
                sel_d    = SEL_W'(next_set(mask_ext, NUM_DIGITS, int'(sel_q)));
                cnt_d    = '0;
                strobe_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            state_d = (GHOST && int'(cnt_d) < BLANK_CYCLES) ? BLANK : ON;
        end
        pwm_clear = (cnt_d == '0);
    end

    scan_pwm #(.BRIGHT_WIDTH(BRIGHT_WIDTH)) u_pwm (
        .clk        (Clk),
        .rst        (Reset),
        .clear      (pwm_clear),
        .brightness (bus.Brightness),
        .gate       (pwm_gate)
    );

    // Anode for the next cycle: only the selected, still-enabled digit may
    // go low, so anode and select always switch on the same edge.
    always_comb begin
        anode_d = '1;
        if (state_d == ON && bus.DigitMask[sel_d] && pwm_gate)
            anode_d = ~(NUM_DIGITS'(1) << sel_d);
    end

    // Scan registers; reset overrides every other event.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            anode_q  <= '1;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            anode_q  <= anode_d;
        end
    end

    assign bus.Anode       = anode_q;
    assign bus.DigitSel    = sel_q;
    assign bus.DigitStrobe = strobe_q;
endmodule

// File: tb/tb_anode_scanner.sv
// Self-checking bench for anode_scanner: directed scenarios plus random
// mask/brightness/reset traffic against a behavioural scan model.
module tb_anode_scanner;
    localparam int ND = 4;
    localparam int DW = 8;
    localparam int BC = 2;
    localparam int BW = 2;
`ifdef GHOST_BLANK_EN
    localparam int BLANK_N = BC;
`else
    localparam int BLANK_N = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    anode_scanner_if #(.NUM_DIGITS(ND), .BRIGHT_WIDTH(BW)) bus ();

    anode_scanner #(
        .NUM_DIGITS   (ND),
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BC),
        .BRIGHT_WIDTH (BW)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: which digit is shown, where in its dwell we are, and whether
    // the display is scanning at all.
    bit         m_active = 1'b0;
    int         m_sel    = 0;
    int         m_cnt    = 0;
    logic [3:0] e_anode  = 4'hF;
    logic       e_strobe = 1'b0;

    function automatic int lowest(logic [3:0] m);
        for (int i = 0; i < ND; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int nxt(logic [3:0] m, int cur);
        for (int k = 1; k <= ND; k++) if (m[(cur + k) % ND]) return (cur + k) % ND;
        return cur;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(bit r, logic [3:0] m, logic [1:0] b);
        if (r) begin
            m_active = 1'b0; m_sel = 0; m_cnt = 0; e_strobe = 1'b0;
        end else if (m == 4'h0) begin
            m_active = 1'b0; m_cnt = 0; e_strobe = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1; m_sel = lowest(m); m_cnt = 0; e_strobe = 1'b1;
        end else if (m_cnt == DW - 1) begin
            m_sel = nxt(m, m_sel); m_cnt = 0; e_strobe = 1'b1;
        end else begin
            m_cnt++; e_strobe = 1'b0;
        end
        e_anode = 4'hF;
        if (m_active && m_cnt >= BLANK_N && m[m_sel[1:0]] &&
            ((m_cnt % 4) < int'(b) || b == 2'd3))
            e_anode[m_sel[1:0]] = 1'b0;
    endtask

    // One clock: advance the model on the inputs seen at the edge, then
    // compare the registered outputs.
    task automatic cyc();
        bit         r;
        logic [3:0] m;
        logic [1:0] b;
        @(posedge clk);
        r = rst; m = bus.DigitMask; b = bus.Brightness;
        model(r, m, b);
        #1;
        check("anode",  32'(bus.Anode),       32'(e_anode));
        check("sel",    32'(bus.DigitSel),    32'(m_sel));
        check("strobe", 32'(bus.DigitStrobe), 32'(e_strobe));
        check("onecold", 32'($countones(~bus.Anode) <= 1), 32'(1));
    endtask

    task automatic wait_pos(int sel, int cnt, int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (m_active && (sel < 0 || m_sel == sel) && m_cnt == cnt) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        check("wait_pos", 32'(found), 32'(1));
    endtask

    initial begin
        int         strobes;
        int         held;
        logic [3:0] mm;
        bus.DigitMask  = 4'hF;
        bus.Brightness = 2'd3;
        rst = 1'b1;
        repeat (2) cyc();
        check("rst_anode", 32'(bus.Anode), 32'hF);
        check("rst_sel",   32'(bus.DigitSel), 32'(0));

        // Full mask, full brightness
        rst = 1'b0;
        cyc();
        check("c1_strobe", 32'(bus.DigitStrobe), 32'(1));
        check("c1_sel",    32'(bus.DigitSel), 32'(0));
        repeat (33) cyc();

        // Sparse mask: digits 1 and 3 only, period 16
        bus.DigitMask = 4'b1010;
        strobes = 0;
        repeat (32) begin
            cyc();
            if (bus.DigitStrobe) strobes++;
            check("bits02_high", 32'({bus.Anode[2], bus.Anode[0]}), 32'(2'b11));
        end
        check("strobes_1010", 32'(strobes), 32'(4));

        // Brightness sweep
        bus.Brightness = 2'd1; repeat (20) cyc();
        bus.Brightness = 2'd0; repeat (10) cyc();
        bus.Brightness = 2'd2; repeat (10) cyc();

        // Mask to zero mid-dwell, then a single digit
        wait_pos(-1, 3, 40);
        held = m_sel;
        bus.DigitMask = 4'h0;
        cyc();
        check("idle_anode", 32'(bus.Anode), 32'hF);
        check("idle_sel",   32'(bus.DigitSel), 32'(held));
        repeat (3) cyc();
        bus.DigitMask = 4'b0100;
        cyc();
        check("wake_strobe", 32'(bus.DigitStrobe), 32'(1));
        check("wake_sel",    32'(bus.DigitSel), 32'(2));
        repeat (20) cyc();

        // Clear the current digit's mask bit at dwell count 3
        bus.DigitMask  = 4'hF;
        bus.Brightness = 2'd3;
        repeat (2) cyc();
        wait_pos(-1, 3, 40);
        mm = 4'hF;
        mm[m_sel[1:0]] = 1'b0;
        bus.DigitMask = mm;
        cyc();
        check("clr_anode", 32'(bus.Anode), 32'hF);
        repeat (3) cyc();
        cyc();
        check("clr_advance", 32'(bus.DigitStrobe), 32'(1));

        // Reset at dwell count 5 of digit 2
        bus.DigitMask = 4'hF;
        wait_pos(2, 5, 80);
        rst = 1'b1;
        cyc();
        check("mid_rst_anode",  32'(bus.Anode), 32'hF);
        check("mid_rst_sel",    32'(bus.DigitSel), 32'(0));
        check("mid_rst_strobe", 32'(bus.DigitStrobe), 32'(0));
        rst = 1'b0;
        repeat (10) cyc();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 15) == 0) bus.DigitMask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0)  bus.Brightness = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
